// File: rtl/cell_raster_reader_pkg.sv
// -----------------------------------------------------------------------------
// cell_raster_reader_pkg
//   Shared geometry and types for the painted-cell bitmap. The paint controller
//   imports this package as well, so cell sizes and address widths have a single
//   source.
//   Contents: screen/cell geometry, derived widths, FSM state enumeration and
//   the row/column to RAM address mapping.
// -----------------------------------------------------------------------------
package cell_raster_reader_pkg;

    localparam int HSIZE  = 128;   // cells per row (640 / SCALE)
    localparam int VSIZE  = 96;    // cell rows (480 / SCALE)
    localparam int SCALE  = 5;     // cell edge in screen pixels
    localparam int XW     = 10;    // pixel x coordinate width
    localparam int YW     = 10;    // pixel y coordinate width

    localparam int CELLS  = HSIZE * VSIZE;
    localparam int ROW_W  = $clog2(VSIZE);
    localparam int COL_W  = $clog2(HSIZE);
    localparam int ADDR_W = $clog2(CELLS);
    localparam int CNT_W  = $clog2(CELLS + 1);
    localparam int PCNT_W = $clog2(CELLS * SCALE * SCALE + 1);

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        WR_RD,
        WR_UPD
    } state_t;

    // Row-major cell address: row*HSIZE + col.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        return ADDR_W'(int'(row) * HSIZE + int'(col));
    endfunction

endpackage

// File: rtl/cell_raster_reader_if.sv
// -----------------------------------------------------------------------------
// cell_raster_reader_if
//   Command channel between the cursor/paint control logic (master) and the
//   bitmap block (slave).
//   wr_valid/wr_ready/wr_row/wr_col : cell-set handshake
//   clr_req                         : single-cycle pulse, clear whole bitmap
//   busy                            : clear sweep in progress
// -----------------------------------------------------------------------------
interface cell_raster_reader_if import cell_raster_reader_pkg::*; ;

    logic             wr_valid;
    logic             wr_ready;
    logic [ROW_W-1:0] wr_row;
    logic [COL_W-1:0] wr_col;
    logic             clr_req;
    logic             busy;

    modport master (
        output wr_valid, wr_row, wr_col, clr_req,
        input  wr_ready, busy
    );

    modport slave (
        input  wr_valid, wr_row, wr_col, clr_req,
        output wr_ready, busy
    );

endinterface

// File: rtl/cell_raster_reader_bitmap_ram.sv
// -----------------------------------------------------------------------------
// cell_bitmap_ram
//   CELLS x 1-bit true dual-port RAM, synchronous read on both ports.
//   CLK             : clock
//   a_addr / a_q    : port A, read only (raster path)
//   b_addr / b_we / b_wd / b_q : port B, read/write, read-first
// -----------------------------------------------------------------------------
module cell_bitmap_ram import cell_raster_reader_pkg::*; (
    input  logic              CLK,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_q,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_we,
    input  logic              b_wd,
    output logic              b_q
);

    // NOTE: the array has no reset; a reset term would stop block-RAM inference.
    // Initialisation is the job of the clear sweep in the controller.
    logic mem [CELLS];

    always_ff @(posedge CLK) begin
        a_q <= mem[a_addr];
    end

    // NOTE: non-blocking on both the read and the write gives read-first
    // behaviour: b_q returns the value stored before this edge's write.
    always_ff @(posedge CLK) begin
        b_q <= mem[b_addr];
        if (b_we) begin
            mem[b_addr] <= b_wd;
        end
    end

endmodule

// File: rtl/cell_raster_reader.sv
// -----------------------------------------------------------------------------
// cell_raster_reader
//   Painted-cell bitmap: accepts cell-set / clear commands, reads the bitmap in
//   raster order to produce a per-pixel "on" flag and tracks the lit-cell count.
//   CLK, RESET        : clock, asynchronous active-high reset
//   cmd (slave)       : cell-set handshake, clear request, busy
//   px_valid/px_x/px_y: current VGA pixel
//   pix_on, pix_valid : pixel result, 2 cycles after the pixel
//   cell_cnt          : number of lit cells
//   pixel_cnt         : cell_cnt * SCALE * SCALE, one cycle behind cell_cnt
// -----------------------------------------------------------------------------
module cell_raster_reader import cell_raster_reader_pkg::*; (
    input  logic                 CLK,
    input  logic                 RESET,
    cell_raster_reader_if.slave  cmd,
    input  logic                 px_valid,
    input  logic [XW-1:0]        px_x,
    input  logic [YW-1:0]        px_y,
    output logic                 pix_on,
    output logic                 pix_valid,
    output logic [CNT_W-1:0]     cell_cnt,
    output logic [PCNT_W-1:0]    pixel_cnt
);

    // ---------------- raster path (port A) ----------------
    logic [XW-1:0]     px_col;
    logic [YW-1:0]     px_row;
    logic              px_in_range;
    logic [ADDR_W-1:0] s0_addr;
    logic              s0_flag, s0_valid, s1_flag, s1_valid;
    logic              ram_a_q;

    assign px_col      = px_x / XW'(SCALE);
    assign px_row      = px_y / YW'(SCALE);
    assign px_in_range = px_valid && (px_x < XW'(HSIZE * SCALE)) && (px_y < YW'(VSIZE * SCALE));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s0_addr  <= '0;
            s0_flag  <= 1'b0;
            s0_valid <= 1'b0;
            s1_flag  <= 1'b0;
            s1_valid <= 1'b0;
        end else begin
            // Out-of-range pixels read address 0 so the RAM is never indexed
            // past CELLS; their result is masked by the flag anyway.
            s0_addr  <= px_in_range ? cell_addr(ROW_W'(px_row), COL_W'(px_col)) : '0;
            s0_flag  <= px_in_range;
            s0_valid <= px_valid;
            s1_flag  <= s0_flag;
            s1_valid <= s0_valid;
        end
    end

    assign pix_on    = ram_a_q & s1_flag;
    assign pix_valid = s1_valid;

    // ---------------- command FSM (port B) ----------------
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sweep_addr, wr_addr, b_addr;
    logic              b_we, b_wd, b_q;
    logic              clr_pend;
    logic              clr_now;
    logic              wr_in_range;

    assign clr_now     = cmd.clr_req || clr_pend;
    assign wr_in_range = (int'(cmd.wr_row) < VSIZE) && (int'(cmd.wr_col) < HSIZE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= CLEAR;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CLEAR:   if (sweep_addr == ADDR_W'(CELLS - 1)) state_d = IDLE;
            IDLE:    if (clr_now)                             state_d = CLEAR;
                     else if (cmd.wr_valid && wr_in_range)    state_d = WR_RD;
            WR_RD:   state_d = WR_UPD;
            WR_UPD:  state_d = IDLE;
            default: state_d = CLEAR;
        endcase
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        cmd.wr_ready = 1'b0;
        cmd.busy     = 1'b0;
        b_addr       = wr_addr;
        b_we         = 1'b0;
        b_wd         = 1'b0;
        unique case (state_q)
            CLEAR: begin
                cmd.busy = 1'b1;
                b_addr   = sweep_addr;
                b_we     = 1'b1;
            end
            IDLE: begin
                // A starting clear wins over a simultaneous write, so ready is
                // withdrawn and the write is not taken.
                cmd.wr_ready = !clr_now;
                b_addr       = wr_in_range ? cell_addr(cmd.wr_row, cmd.wr_col) : '0;
            end
            WR_UPD: begin
                b_we = !b_q;    // only a 0 -> 1 change needs a write
                b_wd = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sweep_addr <= '0;
            wr_addr    <= '0;
            clr_pend   <= 1'b0;
            cell_cnt   <= '0;
            pixel_cnt  <= '0;
        end else begin
            unique case (state_q)
                CLEAR: begin
                    sweep_addr <= sweep_addr + 1'b1;
                    cell_cnt   <= '0;
                    clr_pend   <= 1'b0;   // requests during a sweep are dropped
                end
                IDLE: begin
                    if (clr_now) begin
                        sweep_addr <= '0;
                        cell_cnt   <= '0;
                        clr_pend   <= 1'b0;
                    end else if (cmd.wr_valid && wr_in_range) begin
                        wr_addr <= cell_addr(cmd.wr_row, cmd.wr_col);
                    end
                end
                WR_RD: begin
                    if (cmd.clr_req) clr_pend <= 1'b1;
                end
                WR_UPD: begin
                    if (cmd.clr_req) clr_pend <= 1'b1;
                    if (!b_q && cell_cnt != CNT_W'(CELLS)) cell_cnt <= cell_cnt + 1'b1;
                end
                default: ;
            endcase
            pixel_cnt <= PCNT_W'(cell_cnt) * PCNT_W'(SCALE * SCALE);
        end
    end

    cell_bitmap_ram u_ram (
        .CLK    (CLK),
        .a_addr (s0_addr),
        .a_q    (ram_a_q),
        .b_addr (b_addr),
        .b_we   (b_we),
        .b_wd   (b_wd),
        .b_q    (b_q)
    );

endmodule

// File: tb/tb_cell_raster_reader.sv
// -----------------------------------------------------------------------------
// tb_cell_raster_reader
//   Directed bench for cell_raster_reader: clear sweep timing, cell writes,
//   raster readback, out-of-range commands, clear interactions and reset
//   during a sweep. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_cell_raster_reader;
    import cell_raster_reader_pkg::*;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              px_valid;
    logic [XW-1:0]     px_x;
    logic [YW-1:0]     px_y;
    logic              pix_on, pix_valid;
    logic [CNT_W-1:0]  cell_cnt;
    logic [PCNT_W-1:0] pixel_cnt;

    cell_raster_reader_if cmd_if ();

    cell_raster_reader dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .cmd       (cmd_if),
        .px_valid  (px_valid),
        .px_x      (px_x),
        .px_y      (px_y),
        .pix_on    (pix_on),
        .pix_valid (pix_valid),
        .cell_cnt  (cell_cnt),
        .pixel_cnt (pixel_cnt)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference bitmap and lit-cell count.
    bit lit [CELLS];
    int model_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic model_clear();
        for (int i = 0; i < CELLS; i++) lit[i] = 1'b0;
        model_cnt = 0;
    endtask

    // Counts cycles until busy drops; optionally pulses clr_req at cycle clr_at.
    task automatic wait_sweep(input string tag, input int clr_at);
        int n = 0;
        while (cmd_if.busy === 1'b1 && n < 20000) begin
            step();
            n++;
            cmd_if.clr_req = (n == clr_at);
        end
        cmd_if.clr_req = 1'b0;
        check(tag, n, CELLS);
    endtask

    // One cell-set command issued from IDLE, with handshake timing checks.
    task automatic do_write(input int row, input int col);
        bit in_range = (row < VSIZE) && (col < HSIZE);
        check("ready_before_wr", cmd_if.wr_ready, 1);
        cmd_if.wr_valid = 1'b1;
        cmd_if.wr_row   = ROW_W'(row);
        cmd_if.wr_col   = COL_W'(col);
        step();
        cmd_if.wr_valid = 1'b0;
        if (in_range) begin
            check("ready_wr_rd", cmd_if.wr_ready, 0);
            step();
            check("ready_wr_upd", cmd_if.wr_ready, 0);
            step();
            check("ready_back", cmd_if.wr_ready, 1);
            if (!lit[row * HSIZE + col]) begin
                lit[row * HSIZE + col] = 1'b1;
                model_cnt++;
            end
            check("cell_cnt_wr", cell_cnt, model_cnt);
            step();
            check("pixel_cnt_wr", pixel_cnt, model_cnt * SCALE * SCALE);
        end else begin
            check("ready_oor", cmd_if.wr_ready, 1);
            check("cell_cnt_oor", cell_cnt, model_cnt);
        end
    endtask

    task automatic check_pixel(input string tag, input int x, input int y,
                               input bit v, input bit exp_on);
        px_x     = XW'(x);
        px_y     = YW'(y);
        px_valid = v;
        step();
        px_valid = 1'b0;
        step();
        check({tag, "_on"}, pix_on, exp_on);
        check({tag, "_valid"}, pix_valid, v);
    endtask

    // Pipelined scan, one pixel per cycle, one pixel inside every cell with the
    // offset inside the cell varying from cell to cell.
    task automatic scan_cells(input string tag);
        int mism = 0;
        int nlit = 0;
        for (int i = 0; i < CELLS + 2; i++) begin
            if (i >= 2) begin
                if (pix_on !== lit[i - 2] || pix_valid !== 1'b1) mism++;
                if (pix_on === 1'b1) nlit++;
            end
            if (i < CELLS) begin
                px_x     = XW'((i % HSIZE) * SCALE + (i % SCALE));
                px_y     = YW'((i / HSIZE) * SCALE + ((i / 7) % SCALE));
                px_valid = 1'b1;
            end else begin
                px_valid = 1'b0;
            end
            step();
        end
        check({tag, "_mismatches"}, mism, 0);
        check({tag, "_lit"}, nlit, model_cnt);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, cmd_if.busy, 1);
        check({tag, "_ready"}, cmd_if.wr_ready, 0);
        check({tag, "_cell_cnt"}, cell_cnt, 0);
        check({tag, "_pixel_cnt"}, pixel_cnt, 0);
        check({tag, "_pix_on"}, pix_on, 0);
        check({tag, "_pix_valid"}, pix_valid, 0);
    endtask

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RESET           = 1'b1;
        cmd_if.wr_valid = 1'b0;
        cmd_if.wr_row   = '0;
        cmd_if.wr_col   = '0;
        cmd_if.clr_req  = 1'b0;
        px_valid        = 1'b1;
        px_x            = '0;
        px_y            = '0;
        model_clear();

        // Reset and initial sweep.
        repeat (3) step();
        check_reset_outputs("rst");
        px_valid = 1'b0;
        RESET    = 1'b0;
        wait_sweep("sweep_init", 0);
        check("init_ready", cmd_if.wr_ready, 1);
        check("init_cell_cnt", cell_cnt, 0);
        check("init_pixel_cnt", pixel_cnt, 0);

        // First cell and its 5x5 footprint.
        do_write(2, 3);
        check("cnt_after_23", cell_cnt, 1);
        check("pcnt_after_23", pixel_cnt, 25);
        for (int y = 10; y <= 14; y++)
            for (int x = 15; x <= 19; x++)
                check_pixel("cell23", x, y, 1'b1, 1'b1);
        check_pixel("left_of_23", 14, 12, 1'b1, 1'b0);
        check_pixel("right_of_23", 20, 12, 1'b1, 1'b0);
        check_pixel("blank_23", 16, 11, 1'b0, 1'b0);

        // Repeat write, far corner, out-of-range x aliasing onto (2,3).
        do_write(2, 3);
        do_write(95, 127);
        check("cnt_after_corner", cell_cnt, 2);
        check("pcnt_after_corner", pixel_cnt, 50);
        check_pixel("corner", 639, 479, 1'b1, 1'b1);
        check_pixel("x_beyond", 655, 12, 1'b1, 1'b0);

        // Out-of-range command: accepted, no effect.
        do_write(100, 5);
        check("cnt_after_oor", cell_cnt, 2);
        scan_cells("scan_writes");

        // Clear together with a write in IDLE: clear wins.
        cmd_if.wr_valid = 1'b1;
        cmd_if.wr_row   = 7'd10;
        cmd_if.wr_col   = 7'd10;
        cmd_if.clr_req  = 1'b1;
        #1;
        check("ready_during_clr", cmd_if.wr_ready, 0);
        step();
        cmd_if.wr_valid = 1'b0;
        cmd_if.clr_req  = 1'b0;
        check("clrA_busy", cmd_if.busy, 1);
        check("clrA_cnt", cell_cnt, 0);
        model_clear();
        wait_sweep("sweep_clr_idle", 0);
        check("clrA_cnt_after", cell_cnt, 0);
        check_pixel("clrA_cell23", 17, 12, 1'b1, 1'b0);

        // Clear pulses during WR_RD and WR_UPD: write completes, one clear follows.
        do_write(10, 10);
        cmd_if.wr_valid = 1'b1;
        cmd_if.wr_row   = 7'd50;
        cmd_if.wr_col   = 7'd50;
        step();
        cmd_if.wr_valid = 1'b0;
        cmd_if.clr_req  = 1'b1;
        check("clrB_ready_rd", cmd_if.wr_ready, 0);
        step();
        check("clrB_busy_upd", cmd_if.busy, 0);
        step();
        cmd_if.clr_req = 1'b0;
        check("clrB_busy_idle", cmd_if.busy, 0);
        check("clrB_cnt_done", cell_cnt, 2);
        check("clrB_ready_pend", cmd_if.wr_ready, 0);
        step();
        check("clrB_busy", cmd_if.busy, 1);
        check("clrB_cnt", cell_cnt, 0);
        model_clear();
        wait_sweep("sweep_clr_wr", 100);
        check("clrB_cnt_after", cell_cnt, 0);
        check("clrB_pcnt_after", pixel_cnt, 0);
        check_pixel("clrB_cell5050", 252, 252, 1'b1, 1'b0);

        // Reset 5000 cycles into a sweep with cells lit.
        do_write(0, 0);
        do_write(95, 127);
        cmd_if.clr_req = 1'b1;
        step();
        cmd_if.clr_req = 1'b0;
        check("rstB_busy", cmd_if.busy, 1);
        repeat (4999) step();
        px_x     = XW'(639);
        px_y     = YW'(479);
        px_valid = 1'b1;
        RESET    = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        repeat (3) step();
        check_reset_outputs("rst_hold");
        px_valid = 1'b0;
        RESET    = 1'b0;
        model_clear();
        wait_sweep("sweep_after_rst", 0);
        check("rstB_cnt_after", cell_cnt, 0);
        scan_cells("scan_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
